// File: rtl/scan_counter_display.sv
// rtl/scan_counter_display.sv - DIGITS-digit BCD/hex up/down counter with a multiplexed 7-segment scan driver
// Optional leading-zero blanking: define LEADING_ZERO_BLANK_EN.
module scan_counter_display #(
    parameter int                DIGITS   = 4,
    parameter int                RADIX    = 10,
    parameter int                SCAN_DIV = 1000,
    parameter logic [DIGITS-1:0] DP_MASK  = '0
) (
    input  logic                  CP,
    input  logic                  MRN,
    input  logic                  CE,
    input  logic                  UP,
    input  logic                  PEN,
    input  logic [4*DIGITS-1:0]   Dn,
    input  logic                  BI_N,
    output logic [4*DIGITS-1:0]   Qn,
    output logic                  TC,
    output logic [7:0]            Seg,
    output logic [DIGITS-1:0]     Dig
);

    localparam int         PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int         IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [3:0] MAX_D = 4'(RADIX - 1);

    logic [4*DIGITS-1:0] q_next;
    logic                all_max;
    logic                all_zero;
    logic [PW-1:0]       presc;
    logic [IW-1:0]       scan_idx;
    logic [3:0]          cur_digit;
    logic                cur_dp;
    logic                cur_blank;
    logic [DIGITS-1:0]   lead_zero;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 7'h3F;
            4'h1: seg7 = 7'h06;
            4'h2: seg7 = 7'h5B;
            4'h3: seg7 = 7'h4F;
            4'h4: seg7 = 7'h66;
            4'h5: seg7 = 7'h6D;
            4'h6: seg7 = 7'h7D;
            4'h7: seg7 = 7'h07;
            4'h8: seg7 = 7'h7F;
            4'h9: seg7 = 7'h6F;
            4'hA: seg7 = 7'h77;
            4'hB: seg7 = 7'h7C;
            4'hC: seg7 = 7'h39;
            4'hD: seg7 = 7'h5E;
            4'hE: seg7 = 7'h79;
            default: seg7 = 7'h71;
        endcase
    endfunction

    // Ripple carry/borrow resolves across all digits within one cycle.
    always_comb begin : counter_next
        logic       chain;
        logic [3:0] d;
        logic [3:0] ld;
        chain    = 1'b1;
        d        = '0;
        ld       = '0;
        q_next   = Qn;
        all_max  = 1'b1;
        all_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d        = Qn[4*i +: 4];
            ld       = Dn[4*i +: 4];
            all_max  = all_max & (d == MAX_D);
            all_zero = all_zero & (d == 4'd0);
            if (!PEN) begin
                q_next[4*i +: 4] = (ld > MAX_D) ? MAX_D : ld;
            end else if (CE && chain) begin
                if (UP) begin
                    q_next[4*i +: 4] = (d == MAX_D) ? 4'd0 : d + 4'd1;
                    chain            = (d == MAX_D);
                end else begin
                    q_next[4*i +: 4] = (d == 4'd0) ? MAX_D : d - 4'd1;
                    chain            = (d == 4'd0);
                end
            end
        end
    end

    assign TC = CE & (UP ? all_max : all_zero);

    always_ff @(posedge CP or negedge MRN) begin
        if (!MRN) begin
            Qn <= '0;
        end else begin
            Qn <= q_next;
        end
    end

    always_ff @(posedge CP or negedge MRN) begin
        if (!MRN) begin
            presc    <= '0;
            scan_idx <= '0;
        end else if (presc == PW'(SCAN_DIV - 1)) begin
            presc    <= '0;
            scan_idx <= (scan_idx == IW'(DIGITS - 1)) ? '0 : scan_idx + IW'(1);
        end else begin
            presc    <= presc + PW'(1);
        end
    end

    always_comb begin : digit_select
        cur_digit = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        lead_zero = '0;
`ifdef LEADING_ZERO_BLANK_EN
        begin : lz_scan
            logic zero_above;
            zero_above = 1'b1;
            for (int i = DIGITS - 1; i > 0; i--) begin
                zero_above   = zero_above & (Qn[4*i +: 4] == 4'd0);
                lead_zero[i] = zero_above;
            end
        end
`endif
        for (int i = 0; i < DIGITS; i++) begin
            if (scan_idx == IW'(i)) begin
                cur_digit = Qn[4*i +: 4];
                cur_dp    = DP_MASK[i];
                cur_blank = lead_zero[i];
            end
        end
    end

    always_ff @(posedge CP or negedge MRN) begin
        if (!MRN) begin
            Seg <= 8'h00;
            Dig <= '1;
        end else if (!BI_N) begin
            Seg <= 8'h00;
            Dig <= '1;
        end else begin
            Seg <= {cur_dp, cur_blank ? 7'h00 : seg7(cur_digit)};
            Dig <= ~(DIGITS'(1) << scan_idx);
        end
    end

endmodule

// File: tb/tb_scan_counter_display.sv
// tb/tb_scan_counter_display.sv - randomized self-checking bench for scan_counter_display (BCD and hex instances)
module tb_scan_counter_display;

    localparam int         DIGITS   = 4;
    localparam int         SCAN_DIV = 4;
    localparam logic [3:0] DP       = 4'b0100;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif
    localparam logic [6:0] SEG_TBL [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic        CP = 1'b0;
    logic        MRN, CE, UP, PEN, BI_N;
    logic [15:0] Dn;
    logic [15:0] qn_d, qn_h;
    logic        tc_d, tc_h;
    logic [7:0]  seg_d, seg_h;
    logic [3:0]  dig_d, dig_h;

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned cnt [2];
    int          rad [2] = '{10, 16};
    int          edges;
    logic [7:0]  exp_seg [2];
    logic [3:0]  exp_dig;

    always #5 CP = ~CP;

    scan_counter_display #(.DIGITS(DIGITS), .RADIX(10), .SCAN_DIV(SCAN_DIV), .DP_MASK(DP)) dut_dec (
        .CP(CP), .MRN(MRN), .CE(CE), .UP(UP), .PEN(PEN), .Dn(Dn), .BI_N(BI_N),
        .Qn(qn_d), .TC(tc_d), .Seg(seg_d), .Dig(dig_d));

    scan_counter_display #(.DIGITS(DIGITS), .RADIX(16), .SCAN_DIV(SCAN_DIV), .DP_MASK(DP)) dut_hex (
        .CP(CP), .MRN(MRN), .CE(CE), .UP(UP), .PEN(PEN), .Dn(Dn), .BI_N(BI_N),
        .Qn(qn_h), .TC(tc_h), .Seg(seg_h), .Dig(dig_h));

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    function automatic int unsigned modulus(int r);
        return r ** DIGITS;
    endfunction

    function automatic logic [15:0] enc(int r, int unsigned v);
        logic [15:0] t;
        t = '0;
        for (int i = 0; i < DIGITS; i++) begin
            t[4*i +: 4] = 4'(v % r);
            v = v / r;
        end
        return t;
    endfunction

    function automatic int unsigned load_val(int r, logic [15:0] d);
        int unsigned v;
        int          nib;
        v = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib = int'(d[4*i +: 4]);
            if (nib >= r) nib = r - 1;
            v = v * r + nib;
        end
        return v;
    endfunction

    function automatic logic [7:0] seg_model(int r, int unsigned v, int idx, logic bi);
        int unsigned upper;
        logic        blank;
        if (!bi) return 8'h00;
        upper = v / (r ** idx);
        blank = LZB && (idx > 0) && (upper == 0);
        return {DP[idx], blank ? 7'h00 : SEG_TBL[upper % r]};
    endfunction

    function automatic logic exp_tc(int k);
        return CE && (UP ? (cnt[k] == modulus(rad[k]) - 1) : (cnt[k] == 0));
    endfunction

    // Advances the reference by one CP edge, then samples 1 time unit after it.
    task automatic step();
        int idx;
        idx     = (edges / SCAN_DIV) % DIGITS;
        exp_dig = BI_N ? ~(4'b0001 << idx) : 4'hF;
        for (int k = 0; k < 2; k++) begin
            exp_seg[k] = seg_model(rad[k], cnt[k], idx, BI_N);
            if (!PEN)    cnt[k] = load_val(rad[k], Dn);
            else if (CE) cnt[k] = UP ? (cnt[k] + 1) % modulus(rad[k])
                                     : (cnt[k] + modulus(rad[k]) - 1) % modulus(rad[k]);
        end
        edges++;
        @(posedge CP);
        #1;
    endtask

    task automatic model_reset();
        cnt[0] = 0;
        cnt[1] = 0;
        edges  = 0;
    endtask

    task automatic test_reset();
        MRN = 1'b0; CE = 1'b0; UP = 1'b1; PEN = 1'b1; BI_N = 1'b1; Dn = '0;
        repeat (2) @(posedge CP);
        #1 MRN = 1'b1;
        model_reset();
        CE = 1'b1;
        repeat (7) step();
        #2 MRN = 1'b0;
        #1;
        n_cmp++; if (qn_d !== 16'h0000) begin n_bad++; $display("FAIL reset_qn_dec: got %h want 0000", qn_d); end
        n_cmp++; if (qn_h !== 16'h0000) begin n_bad++; $display("FAIL reset_qn_hex: got %h want 0000", qn_h); end
        n_cmp++; if (seg_d !== 8'h00) begin n_bad++; $display("FAIL reset_seg: got %h want 00", seg_d); end
        n_cmp++; if (dig_d !== 4'hF) begin n_bad++; $display("FAIL reset_dig: got %b want 1111", dig_d); end
        @(posedge CP);
        #1;
        n_cmp++; if (seg_h !== 8'h00 || dig_h !== 4'hF) begin
            n_bad++; $display("FAIL reset_hold: got seg %h dig %b want 00 1111", seg_h, dig_h); end
        MRN = 1'b1;
        CE  = 1'b0;
        model_reset();
        step();
        n_cmp++; if (seg_d !== 8'h3F) begin n_bad++; $display("FAIL first_slot_seg: got %h want 3F", seg_d); end
        n_cmp++; if (dig_d !== 4'b1110) begin n_bad++; $display("FAIL first_slot_dig: got %b want 1110", dig_d); end
        n_cmp++; if (seg_h !== exp_seg[1]) begin n_bad++; $display("FAIL first_slot_seg_hex: got %h want %h", seg_h, exp_seg[1]); end
    endtask

    task automatic test_bcd_carry();
        PEN = 1'b0; Dn = 16'h0999; CE = 1'b0;
        step();
        n_cmp++; if (qn_d !== 16'h0999) begin n_bad++; $display("FAIL load_0999: got %h want 0999", qn_d); end
        PEN = 1'b1; CE = 1'b1; UP = 1'b1;
        step();
        n_cmp++; if (qn_d !== 16'h1000) begin n_bad++; $display("FAIL carry_chain: got %h want 1000", qn_d); end
        n_cmp++; if (qn_h !== enc(16, cnt[1])) begin n_bad++; $display("FAIL carry_hex: got %h want %h", qn_h, enc(16, cnt[1])); end
        PEN = 1'b0; Dn = 16'h9999;
        step();
        PEN = 1'b1;
        #1;
        n_cmp++; if (tc_d !== 1'b1) begin n_bad++; $display("FAIL tc_9999: got %b want 1", tc_d); end
        n_cmp++; if (tc_h !== exp_tc(1)) begin n_bad++; $display("FAIL tc_hex_9999: got %b want %b", tc_h, exp_tc(1)); end
        step();
        n_cmp++; if (qn_d !== 16'h0000) begin n_bad++; $display("FAIL wrap_up: got %h want 0000", qn_d); end
        n_cmp++; if (tc_d !== 1'b0) begin n_bad++; $display("FAIL tc_after_wrap: got %b want 0", tc_d); end
    endtask

    task automatic test_down_clamp();
        PEN = 1'b0; Dn = 16'h00FA; CE = 1'b0;
        step();
        n_cmp++; if (qn_d !== 16'h0099) begin n_bad++; $display("FAIL clamp_dec: got %h want 0099", qn_d); end
        n_cmp++; if (qn_h !== 16'h00FA) begin n_bad++; $display("FAIL load_hex: got %h want 00FA", qn_h); end
        PEN = 1'b1; CE = 1'b1; UP = 1'b0;
        for (int n = 0; n < 100; n++) begin
            #1;
            n_cmp++; if (tc_d !== exp_tc(0)) begin n_bad++; $display("FAIL tc_down_dec: got %b want %b", tc_d, exp_tc(0)); end
            n_cmp++; if (tc_h !== exp_tc(1)) begin n_bad++; $display("FAIL tc_down_hex: got %b want %b", tc_h, exp_tc(1)); end
            step();
            n_cmp++; if (qn_d !== enc(10, cnt[0])) begin n_bad++; $display("FAIL down_dec: got %h want %h", qn_d, enc(10, cnt[0])); end
        end
        n_cmp++; if (qn_d !== 16'h9999) begin n_bad++; $display("FAIL borrow_wrap: got %h want 9999", qn_d); end
    endtask

    task automatic test_scan();
        PEN = 1'b0; Dn = 16'h1234; CE = 1'b0; UP = 1'b1;
        step();
        PEN = 1'b1;
        for (int n = 0; n < 20; n++) begin
            step();
            n_cmp++; if (seg_d !== exp_seg[0]) begin n_bad++; $display("FAIL scan_seg: got %h want %h", seg_d, exp_seg[0]); end
            n_cmp++; if (dig_d !== exp_dig) begin n_bad++; $display("FAIL scan_dig: got %b want %b", dig_d, exp_dig); end
            n_cmp++; if (seg_h !== exp_seg[1]) begin n_bad++; $display("FAIL scan_seg_hex: got %h want %h", seg_h, exp_seg[1]); end
        end
    endtask

    task automatic test_priority_blank();
        PEN = 1'b0; CE = 1'b1; UP = 1'b1; Dn = 16'h0005;
        step();
        n_cmp++; if (qn_d !== 16'h0005) begin n_bad++; $display("FAIL load_priority: got %h want 0005", qn_d); end
        PEN = 1'b1; BI_N = 1'b0;
        for (int n = 0; n < 10; n++) begin
            step();
            n_cmp++; if (seg_d !== 8'h00 || dig_d !== 4'hF) begin
                n_bad++; $display("FAIL blank: got seg %h dig %b want 00 1111", seg_d, dig_d); end
            n_cmp++; if (qn_d !== enc(10, cnt[0])) begin n_bad++; $display("FAIL blank_count: got %h want %h", qn_d, enc(10, cnt[0])); end
        end
        BI_N = 1'b1;
    endtask

    task automatic test_hex();
        PEN = 1'b0; Dn = 16'h00AF; CE = 1'b0;
        step();
        PEN = 1'b1;
        n_cmp++; if (qn_d !== 16'h0099) begin n_bad++; $display("FAIL hex_load_clamp_dec: got %h want 0099", qn_d); end
        for (int n = 0; n < 17; n++) begin
            step();
            n_cmp++; if (seg_h !== exp_seg[1]) begin n_bad++; $display("FAIL hex_seg: got %h want %h", seg_h, exp_seg[1]); end
            n_cmp++; if (dig_h !== exp_dig) begin n_bad++; $display("FAIL hex_dig: got %b want %b", dig_h, exp_dig); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            CE   = 1'($urandom_range(0, 3) != 0);
            UP   = 1'($urandom_range(0, 1));
            PEN  = 1'($urandom_range(0, 9) != 0);
            BI_N = 1'($urandom_range(0, 5) != 0);
            Dn   = 16'($urandom);
            #1;
            n_cmp++; if (tc_d !== exp_tc(0)) begin n_bad++; $display("FAIL rnd_tc_dec: got %b want %b", tc_d, exp_tc(0)); end
            n_cmp++; if (tc_h !== exp_tc(1)) begin n_bad++; $display("FAIL rnd_tc_hex: got %b want %b", tc_h, exp_tc(1)); end
            step();
            n_cmp++; if (qn_d !== enc(10, cnt[0])) begin n_bad++; $display("FAIL rnd_qn_dec: got %h want %h", qn_d, enc(10, cnt[0])); end
            n_cmp++; if (qn_h !== enc(16, cnt[1])) begin n_bad++; $display("FAIL rnd_qn_hex: got %h want %h", qn_h, enc(16, cnt[1])); end
            n_cmp++; if (seg_d !== exp_seg[0] || dig_d !== exp_dig) begin
                n_bad++; $display("FAIL rnd_disp_dec: got %h %b want %h %b", seg_d, dig_d, exp_seg[0], exp_dig); end
            n_cmp++; if (seg_h !== exp_seg[1] || dig_h !== exp_dig) begin
                n_bad++; $display("FAIL rnd_disp_hex: got %h %b want %h %b", seg_h, dig_h, exp_seg[1], exp_dig); end
        end
    endtask

    initial begin
        test_reset();
        test_bcd_carry();
        test_down_clamp();
        test_scan();
        test_priority_blank();
        test_hex();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
